// File: rtl/wasca_perf_event_master_if.sv
// Avalon-MM write-only link from the perf event master to the performance counter's control slave.
// Handshake: a transfer is presented while avm_write=1; address/data stay stable until an edge with avm_waitrequest=0 accepts it.
interface wasca_perf_event_master_if;
  logic [2:0]  avm_address;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest;

  modport master (
    output avm_address,
    output avm_write,
    output avm_writedata,
    input  avm_waitrequest
  );

  modport slave (
    input  avm_address,
    input  avm_write,
    input  avm_writedata,
    output avm_waitrequest
  );
endinterface

// File: rtl/wasca_perf_event_master.sv
// Turns section start/stop/clear event pulses into queued Avalon-MM writes to the perf counter slave.
// One command is enqueued per cycle; losers and queue-full losses are counted in a saturating drop counter.
module wasca_perf_event_master #(
  parameter int DEPTH  = 4,
  parameter int DROP_W = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [1:0]                start_evt,
  input  logic [1:0]                stop_evt,
  input  logic                      clear_evt,
  input  logic                      status_clr,
  wasca_perf_event_master_if.master avm,
  output logic                      busy,
  output logic                      overflow,
  output logic [DROP_W-1:0]         drop_count,
  output logic [1:0]                fsm_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = DROP_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  // Queue entry: {is_clear, address}; data is 1 for CLEAR, 0 otherwise.
  logic [3:0]    mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, rd_next;
  logic [CW-1:0] count, count_d;

  state_t        state_q, state_d;
  logic          write_q, write_d;
  logic [2:0]    addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic          pop;
  logic [3:0]    head;

  logic [4:0]    ev;
  logic [2:0]    n_set;
  logic          win_valid, win_clear;
  logic [2:0]    win_addr;
  logic          q_full, push_ok;
  logic [2:0]    lost;
  logic          mem_we;
  logic [PW-1:0] mem_waddr;

  logic [DROP_W-1:0] drop_base, drop_d;
  logic [SW-1:0]     drop_sum;

  // Event bits in priority order, MSB highest: clear, stop0, stop1, start0, start1.
  always_comb begin
    ev        = enable ? {clear_evt, stop_evt[0], stop_evt[1], start_evt[0], start_evt[1]} : 5'b0;
    n_set     = 3'd0;
    for (int i = 0; i < 5; i++) n_set = n_set + {2'b00, ev[i]};
    win_valid = 1'b1;
    win_clear = 1'b0;
    win_addr  = 3'd0;
    if (ev[4]) begin
      win_clear = 1'b1;
      win_addr  = 3'd0;
    end else if (ev[3]) begin
      win_addr  = 3'd0;
    end else if (ev[2]) begin
      win_addr  = 3'd4;
    end else if (ev[1]) begin
      win_addr  = 3'd1;
    end else if (ev[0]) begin
      win_addr  = 3'd5;
    end else begin
      win_valid = 1'b0;
    end
  end

  assign head = mem[rd_ptr];

  // Transfer FSM: IDLE loads the queue head, WRITE waits out the stall, GAP separates transfers.
  always_comb begin
    state_d = state_q;
    write_d = write_q;
    addr_d  = addr_q;
    data_d  = data_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          write_d = 1'b1;
          addr_d  = head[2:0];
          data_d  = {31'd0, head[3]};
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (!avm.avm_waitrequest) begin
          write_d = 1'b0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: begin
        write_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // A full queue still accepts a push when the head leaves in the same cycle.
  always_comb begin
    q_full    = (count == CW'(DEPTH));
    push_ok   = win_valid && (win_clear || !q_full || pop);
    lost      = (win_valid ? n_set - 3'd1 : 3'd0) + {2'b00, win_valid && !push_ok};
    rd_next   = pop ? rd_ptr + PW'(1) : rd_ptr;
    mem_we    = push_ok;
    mem_waddr = win_clear ? rd_next : wr_ptr;
    if (win_clear) count_d = CW'(1);
    else           count_d = count + CW'(push_ok) - CW'(pop);
  end

  // A clear drops every not-yet-issued entry and leaves CLEAR as the sole entry.
  always_comb begin
    drop_base = status_clr ? '0 : drop_count;
    drop_sum  = {1'b0, drop_base} + SW'(lost);
    drop_d    = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= {win_clear, win_addr};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_next;
      count  <= count_d;
      if (win_clear)    wr_ptr <= rd_next + PW'(1);
      else if (push_ok) wr_ptr <= wr_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      write_q <= 1'b0;
      addr_q  <= 3'd0;
      data_q  <= 32'd0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy    <= (count_d != '0) || (state_d != S_IDLE);
    end
  end

  // A loss in the same cycle as status_clr wins: counter restarts from the new losses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (lost != 3'd0) begin
      overflow   <= 1'b1;
      drop_count <= drop_d;
    end else if (status_clr) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

  assign avm.avm_address   = addr_q;
  assign avm.avm_write     = write_q;
  assign avm.avm_writedata = data_q;
  assign fsm_state         = state_q;

endmodule

// File: tb/tb_wasca_perf_event_master.sv
// Directed bench for wasca_perf_event_master: bus transfers are captured by a monitor and
// compared against hand-written expected transfers (length in cycles, address, data).
module tb_wasca_perf_event_master;
  localparam int DROP_W = 16;
  localparam int W = 43;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic [1:0]        start_evt, stop_evt;
  logic              clear_evt, status_clr;
  logic              busy, overflow;
  logic [DROP_W-1:0] drop_count;
  logic [1:0]        fsm_state;

  wasca_perf_event_master_if bus();

  wasca_perf_event_master #(.DEPTH(4), .DROP_W(DROP_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .start_evt  (start_evt),
    .stop_evt   (stop_evt),
    .clear_evt  (clear_evt),
    .status_clr (status_clr),
    .avm        (bus),
    .busy       (busy),
    .overflow   (overflow),
    .drop_count (drop_count),
    .fsm_state  (fsm_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  int hi_cnt = 0;

  // Monitor: item = {cycles write was high, address, data}, pushed when accepted.
  always @(negedge clk) begin
    if (reset) hi_cnt = 0;
    else if (bus.avm_write) begin
      hi_cnt++;
      if (!bus.avm_waitrequest) begin
        got_q.push_back({hi_cnt[7:0], bus.avm_address, bus.avm_writedata});
        hi_cnt = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [W-1:0] xfer(input int len, input logic [2:0] a, input logic [31:0] d);
    logic [7:0] l;
    l = len[7:0];
    return {l, a, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [1:0] st, input logic [1:0] sp, input logic cl, input logic sc);
    start_evt  = st;
    stop_evt   = sp;
    clear_evt  = cl;
    status_clr = sc;
    tick();
    start_evt  = 2'b00;
    stop_evt   = 2'b00;
    clear_evt  = 1'b0;
    status_clr = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int cyc;
    cyc = 0;
    while (busy && cyc < 300) begin
      tick();
      cyc++;
    end
    check({tag, "_idle_timeout"}, 64'(busy), 64'd0);
    tick();
  endtask

  task automatic compare_writes(input string tag);
    int n;
    check({tag, "_n_writes"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_xfer%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [1:0] st_v [6];
    logic [1:0] sp_v [6];

    reset = 1'b1; enable = 1'b1;
    start_evt = 2'b00; stop_evt = 2'b00; clear_evt = 1'b0; status_clr = 1'b0;
    bus.avm_waitrequest = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_write", 64'(bus.avm_write), 64'd0);
    check("rst_addr", 64'(bus.avm_address), 64'd0);
    check("rst_data", 64'(bus.avm_writedata), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_drop", 64'(drop_count), 64'd0);
    check("rst_state", 64'(fsm_state), 64'd0);

    // 1: start0, then stop0 20 cycles later; zero-wait latency.
    pulse(2'b01, 2'b00, 1'b0, 1'b0);
    check("t1_busy_k", 64'(busy), 64'd1);
    check("t1_write_k", 64'(bus.avm_write), 64'd0);
    tick();
    check("t1_write_k1", 64'(bus.avm_write), 64'd1);
    check("t1_addr_k1", 64'(bus.avm_address), 64'd1);
    tick();
    check("t1_write_k2", 64'(bus.avm_write), 64'd0);
    tick();
    check("t1_busy_k3", 64'(busy), 64'd0);
    repeat (17) tick();
    pulse(2'b00, 2'b01, 1'b0, 1'b0);
    wait_idle("t1");
    exp_q.push_back(xfer(1, 3'd1, 32'd0));
    exp_q.push_back(xfer(1, 3'd0, 32'd0));
    compare_writes("t1");

    // 2: both starts in one cycle -> start0 wins, one loss.
    pulse(2'b11, 2'b00, 1'b0, 1'b0);
    check("t2_drop", 64'(drop_count), 64'd1);
    check("t2_ovf", 64'(overflow), 64'd1);
    wait_idle("t2");
    exp_q.push_back(xfer(1, 3'd1, 32'd0));
    compare_writes("t2");
    pulse(2'b00, 2'b00, 1'b0, 1'b1);
    check("t2_clr_drop", 64'(drop_count), 64'd0);
    check("t2_clr_ovf", 64'(overflow), 64'd0);

    // 3: stalled first write, six pulses -> four queued, one lost.
    st_v = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b01, 2'b10};
    sp_v = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00};
    bus.avm_waitrequest = 1'b1;
    for (int i = 0; i < 6; i++) begin
      pulse(st_v[i], sp_v[i], 1'b0, 1'b0);
      if (i >= 1) begin
        check($sformatf("t3_hold_write%0d", i), 64'(bus.avm_write), 64'd1);
        check($sformatf("t3_hold_addr%0d", i), 64'(bus.avm_address), 64'd1);
      end
    end
    check("t3_drop", 64'(drop_count), 64'd1);
    check("t3_ovf", 64'(overflow), 64'd1);
    tick();
    check("t3_hold_write6", 64'(bus.avm_write), 64'd1);
    bus.avm_waitrequest = 1'b0;
    wait_idle("t3");
    exp_q.push_back(xfer(6, 3'd1, 32'd0));
    exp_q.push_back(xfer(1, 3'd5, 32'd0));
    exp_q.push_back(xfer(1, 3'd0, 32'd0));
    exp_q.push_back(xfer(1, 3'd4, 32'd0));
    exp_q.push_back(xfer(1, 3'd1, 32'd0));
    compare_writes("t3");
    pulse(2'b00, 2'b00, 1'b0, 1'b1);

    // 4: clear flushes three queued entries; in-flight write completes.
    bus.avm_waitrequest = 1'b1;
    pulse(2'b01, 2'b00, 1'b0, 1'b0);
    pulse(2'b10, 2'b00, 1'b0, 1'b0);
    pulse(2'b00, 2'b01, 1'b0, 1'b0);
    pulse(2'b00, 2'b10, 1'b0, 1'b0);
    pulse(2'b00, 2'b00, 1'b1, 1'b0);
    bus.avm_waitrequest = 1'b0;
    check("t4_drop", 64'(drop_count), 64'd0);
    check("t4_ovf", 64'(overflow), 64'd0);
    wait_idle("t4");
    exp_q.push_back(xfer(4, 3'd1, 32'd0));
    exp_q.push_back(xfer(1, 3'd0, 32'd1));
    compare_writes("t4");

    // 5: reset in WRITE with a stalled slave and a queued entry.
    bus.avm_waitrequest = 1'b1;
    pulse(2'b01, 2'b00, 1'b0, 1'b0);
    pulse(2'b10, 2'b00, 1'b0, 1'b0);
    check("t5_write_pre", 64'(bus.avm_write), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("t5_write_rst", 64'(bus.avm_write), 64'd0);
    check("t5_busy_rst", 64'(busy), 64'd0);
    check("t5_state_rst", 64'(fsm_state), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    bus.avm_waitrequest = 1'b0;
    repeat (10) tick();
    check("t5_busy_after", 64'(busy), 64'd0);
    compare_writes("t5");

    // Disabled: events ignored entirely.
    enable = 1'b0;
    pulse(2'b11, 2'b11, 1'b1, 1'b0);
    check("dis_drop", 64'(drop_count), 64'd0);
    check("dis_busy", 64'(busy), 64'd0);
    enable = 1'b1;

    // 6: loss coinciding with status_clr, then saturation.
    pulse(2'b11, 2'b00, 1'b0, 1'b0);
    check("t6_drop_pre", 64'(drop_count), 64'd1);
    pulse(2'b11, 2'b00, 1'b0, 1'b1);
    check("t6_clr_loss_drop", 64'(drop_count), 64'd1);
    check("t6_clr_loss_ovf", 64'(overflow), 64'd1);
    pulse(2'b00, 2'b00, 1'b0, 1'b1);
    check("t6_clr_drop", 64'(drop_count), 64'd0);
    wait_idle("t6a");
    got_q.delete();
    start_evt = 2'b11; stop_evt = 2'b11; clear_evt = 1'b1;
    repeat (16383) tick();
    check("t6_sat_pre", 64'(drop_count), 64'hFFFC);
    tick();
    check("t6_sat_hit", 64'(drop_count), 64'hFFFF);
    start_evt = 2'b01; stop_evt = 2'b11; clear_evt = 1'b1;
    tick();
    start_evt = 2'b00; stop_evt = 2'b00; clear_evt = 1'b0;
    check("t6_sat_hold", 64'(drop_count), 64'hFFFF);
    check("t6_sat_ovf", 64'(overflow), 64'd1);
    wait_idle("t6b");
    got_q.delete();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
